// File: rtl/pe_feeder_pkg.sv
`default_nettype none
// ============================================================================
// pe_feeder_pkg : shared types and constants for the PE load sequencer
// Revision      : 1.0
// ============================================================================
package pe_feeder_pkg;

    localparam int DefDataSize  = 8;
    localparam int DefSpadDepth = 16;
    localparam int DefCntW      = 8;
    localparam int IdxW         = $clog2(DefSpadDepth);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FILL_W  = 3'd1,
        ST_FILL_A  = 3'd2,
        ST_BURST_W = 3'd3,
        ST_BURST_A = 3'd4,
        ST_GAP     = 3'd5,
        ST_START   = 3'd6,
        ST_WAIT    = 3'd7
    } state_e;

    typedef struct packed {
        logic [DefCntW-1:0] wcount;
        logic [DefCntW-1:0] acount;
    } job_cfg_t;

    // The PE reuses weight slots across activations, so a job never carries
    // more weights than activations.
    function automatic logic cfg_valid(input logic [DefCntW-1:0] w,
                                       input logic [DefCntW-1:0] a,
                                       input int                 depth);
        return (w != '0) && (int'(w) <= depth) && (int'(a) <= depth) && (a >= w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pe_feeder_buf.sv
`default_nettype none
// ============================================================================
// feeder_buf : register array, one synchronous write port, one async read
// Revision   : 1.0
// ============================================================================
module feeder_buf
    import pe_feeder_pkg::*;
#(
    parameter int Width = DefDataSize,
    parameter int Depth = DefSpadDepth,
    parameter int AddrW = IdxW
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/pe_feeder.sv
`default_nettype none
// ============================================================================
// pe_feeder : stages one weight/activation job and replays it to a PE
// Revision  : 1.0
// ============================================================================
module pe_feeder
    import pe_feeder_pkg::*;
#(
    parameter int DataSize  = DefDataSize,
    parameter int SpadDepth = DefSpadDepth,
    parameter int CntW      = DefCntW
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                cmd_go,
    input  logic [CntW-1:0]     cfg_wcount,
    input  logic [CntW-1:0]     cfg_acount,
    input  logic [DataSize-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [DataSize-1:0] weights_o,
    output logic [DataSize-1:0] acts_o,
    output logic                ctrl_loadw,
    output logic                ctrl_loada,
    output logic                ctrl_start,
    input  logic                pe_done_i,
    output logic                busy,
    output logic                job_done,
    output logic                cfg_err
);

    localparam int AddrW = $clog2(SpadDepth);

    state_e              state_q;
    job_cfg_t            cfg_q;
    logic [CntW-1:0]     idx_q;
    logic                in_ready_q, busy_q, job_done_q, cfg_err_q;
    logic                loadw_q, loada_q, start_q;
    logic [DataSize-1:0] weights_q, acts_q;

    logic                w_beat;
    logic [CntW-1:0]     w_idx_inc;
    logic [AddrW-1:0]    w_wraddr, w_araddr;
    logic [DataSize-1:0] w_wrdata, w_ardata;

    assign w_beat    = in_valid && in_ready_q;
    assign w_idx_inc = idx_q + CntW'(1);
    // Outside its burst each read port sits on entry 0, ready for the first word.
    assign w_wraddr  = (state_q == ST_BURST_W) ? idx_q[AddrW-1:0] : '0;
    assign w_araddr  = (state_q == ST_BURST_A) ? idx_q[AddrW-1:0] : '0;

    feeder_buf #(.Width(DataSize), .Depth(SpadDepth), .AddrW(AddrW)) u_wbuf (
        .clk     (clk),
        .we_i    (w_beat && (state_q == ST_FILL_W)),
        .waddr_i (idx_q[AddrW-1:0]),
        .wdata_i (in_data),
        .raddr_i (w_wraddr),
        .rdata_o (w_wrdata)
    );

    feeder_buf #(.Width(DataSize), .Depth(SpadDepth), .AddrW(AddrW)) u_abuf (
        .clk     (clk),
        .we_i    (w_beat && (state_q == ST_FILL_A)),
        .waddr_i (idx_q[AddrW-1:0]),
        .wdata_i (in_data),
        .raddr_i (w_araddr),
        .rdata_o (w_ardata)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= ST_IDLE;
            cfg_q      <= '0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            job_done_q <= 1'b0;
            cfg_err_q  <= 1'b0;
            loadw_q    <= 1'b0;
            loada_q    <= 1'b0;
            start_q    <= 1'b0;
            weights_q  <= '0;
            acts_q     <= '0;
        end else begin
            cfg_err_q  <= 1'b0;
            job_done_q <= 1'b0;
            start_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    busy_q <= 1'b0;
                    if (cmd_go) begin
                        if (cfg_valid(cfg_wcount, cfg_acount, SpadDepth)) begin
                            cfg_q      <= '{wcount: cfg_wcount, acount: cfg_acount};
                            idx_q      <= '0;
                            busy_q     <= 1'b1;
                            in_ready_q <= 1'b1;
                            state_q    <= ST_FILL_W;
                        end else begin
                            cfg_err_q  <= 1'b1;
                        end
                    end
                end
                ST_FILL_W: begin
                    if (w_beat) begin
                        if (w_idx_inc == cfg_q.wcount) begin
                            idx_q   <= '0;
                            state_q <= ST_FILL_A;
                        end else begin
                            idx_q   <= w_idx_inc;
                        end
                    end
                end
                ST_FILL_A: begin
                    if (w_beat) begin
                        if (w_idx_inc == cfg_q.acount) begin
                            in_ready_q <= 1'b0;
                            loadw_q    <= 1'b1;
                            weights_q  <= w_wrdata;
                            idx_q      <= CntW'(1);
                            state_q    <= ST_BURST_W;
                        end else begin
                            idx_q      <= w_idx_inc;
                        end
                    end
                end
                ST_BURST_W: begin
                    if (idx_q == cfg_q.wcount) begin
                        loadw_q   <= 1'b0;
                        weights_q <= '0;
                        loada_q   <= 1'b1;
                        acts_q    <= w_ardata;
                        idx_q     <= CntW'(1);
                        state_q   <= ST_BURST_A;
                    end else begin
                        weights_q <= w_wrdata;
                        idx_q     <= w_idx_inc;
                    end
                end
                ST_BURST_A: begin
                    if (idx_q == cfg_q.acount) begin
                        loada_q <= 1'b0;
                        acts_q  <= '0;
                        idx_q   <= '0;
                        state_q <= ST_GAP;
                    end else begin
                        acts_q  <= w_ardata;
                        idx_q   <= w_idx_inc;
                    end
                end
                ST_GAP: begin
                    start_q <= 1'b1;
                    state_q <= ST_START;
                end
                ST_START: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (pe_done_i) begin
                        job_done_q <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign job_done   = job_done_q;
    assign cfg_err    = cfg_err_q;
    assign ctrl_loadw = loadw_q;
    assign ctrl_loada = loada_q;
    assign ctrl_start = start_q;
    assign weights_o  = weights_q;
    assign acts_o     = acts_q;

endmodule
`default_nettype wire

// File: tb/tb_pe_feeder.sv
`default_nettype none
// ============================================================================
// tb_pe_feeder : self-checking bench for pe_feeder
// Revision     : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_pe_feeder;

    localparam int DW = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          cmd_go = 1'b0;
    logic [CW-1:0] cfg_wcount = '0;
    logic [CW-1:0] cfg_acount = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] weights_o, acts_o;
    logic          ctrl_loadw, ctrl_loada, ctrl_start;
    logic          pe_done_i = 1'b0;
    logic          busy, job_done, cfg_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pe_feeder #(.DataSize(DW), .SpadDepth(16), .CntW(CW)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .cmd_go     (cmd_go),
        .cfg_wcount (cfg_wcount),
        .cfg_acount (cfg_acount),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .weights_o  (weights_o),
        .acts_o     (acts_o),
        .ctrl_loadw (ctrl_loadw),
        .ctrl_loada (ctrl_loada),
        .ctrl_start (ctrl_start),
        .pe_done_i  (pe_done_i),
        .busy       (busy),
        .job_done   (job_done),
        .cfg_err    (cfg_err)
    );

    // {busy, in_ready, job_done, cfg_err, start, loadw, loada, weights, acts}
    function automatic logic [22:0] obs();
        return {busy, in_ready, job_done, cfg_err, ctrl_start, ctrl_loadw,
                ctrl_loada, weights_o, acts_o};
    endfunction

    function automatic logic [22:0] mk(input bit b, input bit r, input bit jd,
                                       input bit ce, input bit st, input bit lw,
                                       input bit la, input logic [7:0] wd,
                                       input logic [7:0] ad);
        return {b, r, jd, ce, st, lw, la, wd, ad};
    endfunction

    task automatic check(input string name, input logic [22:0] act, input logic [22:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %06h expected %06h", name, act, exp);
        end
    endtask

    // mode: 0 valid always, 1 valid every other cycle, 2 random valid
    task automatic run_job(input int w, input int a, input logic [7:0] data[$],
                           input int mode, input int done_dly, input bit inject,
                           input bit abort);
        int sent;
        int guard;
        bit beat;
        logic [22:0] exp;
        @(negedge clk);
        cfg_wcount = CW'(w);
        cfg_acount = CW'(a);
        cmd_go     = 1'b1;
        @(negedge clk);
        cmd_go = 1'b0;
        check("go_accept", obs(), mk(1, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00));
        sent  = 0;
        guard = 0;
        while (sent < w + a && guard < 2000) begin
            check("fill_quiet", obs(), mk(1, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00));
            in_data = data[sent];
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = (guard % 2 == 0);
                default: in_valid = ($urandom_range(0, 2) != 0);
            endcase
            if (inject && sent == 1) begin
                cmd_go     = 1'b1;
                pe_done_i  = 1'b1;
                cfg_wcount = CW'(1);
                cfg_acount = CW'(1);
            end
            beat = in_valid && in_ready;
            @(negedge clk);
            if (beat) sent++;
            cmd_go    = 1'b0;
            pe_done_i = 1'b0;
            guard++;
        end
        check("fill_count", 23'(sent), 23'(w + a));
        in_valid = 1'b1;
        in_data  = 8'hEE;
        for (int k = 0; k < w + a + 2; k++) begin
            if (k < w)           exp = mk(1, 0, 0, 0, 0, 1, 0, data[k], 8'h00);
            else if (k < w + a)  exp = mk(1, 0, 0, 0, 0, 0, 1, 8'h00, data[k]);
            else if (k == w + a) exp = mk(1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
            else                 exp = mk(1, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00);
            check("replay", obs(), exp);
            if (abort && k == w + 1) begin
                #2 nrst = 1'b0;
                #1 check("reset_async", obs(), '0);
                @(negedge clk);
                check("reset_hold", obs(), '0);
                in_valid = 1'b0;
                nrst     = 1'b1;
                return;
            end
            @(negedge clk);
            in_valid = 1'b0;
        end
        for (int d = 0; d < done_dly; d++) begin
            check("wait_quiet", obs(), mk(1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
            @(negedge clk);
        end
        pe_done_i = 1'b1;
        @(negedge clk);
        pe_done_i = 1'b0;
        check("job_done", obs(), mk(1, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00));
        @(negedge clk);
        check("idle_after", obs(), '0);
    endtask

    task automatic bad_cfg(input int w, input int a);
        @(negedge clk);
        cfg_wcount = CW'(w);
        cfg_acount = CW'(a);
        cmd_go     = 1'b1;
        @(negedge clk);
        cmd_go = 1'b0;
        check("cfg_err", obs(), mk(0, 0, 0, 1, 0, 0, 0, 8'h00, 8'h00));
        @(negedge clk);
        check("cfg_err_clear", obs(), '0);
    endtask

    typedef struct {
        int w;
        int a;
        bit err;
        int mode;
        int dly;
        bit inject;
    } vec_t;

    initial begin
        vec_t        vecs[9];
        logic [7:0]  q[$];
        int          w, a;

        vecs[0] = '{3, 5, 0, 0, 20, 0};
        vecs[1] = '{3, 5, 0, 1, 4, 0};
        vecs[2] = '{0, 5, 1, 0, 0, 0};
        vecs[3] = '{17, 17, 1, 0, 0, 0};
        vecs[4] = '{3, 2, 1, 0, 0, 0};
        vecs[5] = '{16, 16, 0, 0, 3, 0};
        vecs[6] = '{3, 5, 0, 0, 6, 1};
        vecs[7] = '{1, 1, 0, 1, 0, 0};
        vecs[8] = '{16, 17, 1, 0, 0, 0};

        @(negedge clk);
        check("reset_state", obs(), '0);
        nrst = 1'b1;

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].err) begin
                bad_cfg(vecs[i].w, vecs[i].a);
            end else begin
                q = {};
                for (int k = 0; k < vecs[i].w; k++) q.push_back(8'(k + 1));
                for (int k = 0; k < vecs[i].a; k++) q.push_back(8'(k + 10));
                run_job(vecs[i].w, vecs[i].a, q, vecs[i].mode, vecs[i].dly,
                        vecs[i].inject, 1'b0);
            end
        end

        // Reset in the middle of the activation burst, then a fresh job.
        q = {1, 2, 3, 10, 11, 12, 13, 14};
        run_job(3, 5, q, 0, 0, 1'b0, 1'b1);
        q = {7, 8, 9, 10};
        run_job(2, 2, q, 0, 2, 1'b0, 1'b0);

        for (int r = 0; r < 40; r++) begin
            w = $urandom_range(0, 18);
            a = $urandom_range(0, 18);
            if (w >= 1 && w <= 16 && a <= 16 && a >= w) begin
                q = {};
                for (int k = 0; k < w + a; k++) q.push_back(8'($urandom_range(0, 255)));
                run_job(w, a, q, 2, $urandom_range(0, 6), 1'b0, 1'b0);
            end else begin
                bad_cfg(w, a);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
